// File: rtl/bram_stream_pkg.sv
// Shared types and sizing for the BRAM range reader.
package bram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int FIFO_DEPTH = 4;
  localparam int PIPE_LAT   = 2;

endpackage

// File: rtl/stream_fifo.sv
// Show-ahead synchronous FIFO; head is valid whenever empty is low.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop && !empty;
  // A push into a full FIFO is only allowed when the head leaves in the same cycle
  assign w_do_push = push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/bram_stream_reader.sv
// Streams a contiguous, wrapping address range out of a registered-output BRAM port
// as a valid/ready stream, using credits so the small output FIFO never overflows.
//
// state | meaning
// IDLE  | waiting for start; a zero-length start only pulses done
// RUN   | issuing reads while FIFO occupancy plus in-flight reads leaves room
// DRAIN | all reads issued; waiting for the last beat handshake
module bram_stream_reader
  import bram_stream_pkg::*;
#(
  parameter int DATA = 72,
  parameter int ADDR = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR-1:0]   base_addr,
  input  logic [ADDR:0]     length,
  output logic              busy,
  output logic              done,
  output logic [ADDR-1:0]   mem_addr,
  output logic              mem_wr,
  output logic [DATA-1:0]   mem_din,
  input  logic [DATA-1:0]   mem_dout,
  output logic [DATA-1:0]   m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
);

  localparam int CW = $clog2(FIFO_DEPTH+1);

  state_t              r_state;
  logic [ADDR-1:0]     r_addr;
  logic [ADDR-1:0]     r_mem_addr;
  logic [ADDR:0]       r_remain;
  logic [PIPE_LAT-1:0] r_tag_vld;
  logic [PIPE_LAT-1:0] r_tag_last;
  logic                r_busy;
  logic                r_done;

  logic [DATA:0]       w_head;
  logic [CW-1:0]       w_fifo_count;
  logic                w_fifo_empty;
  logic [CW-1:0]       w_inflight;
  logic                w_credit;
  logic                w_issue;
  logic                w_valid;
  logic                w_pop;
  logic                w_last_hs;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) w_inflight = w_inflight + CW'(r_tag_vld[i]);
  end

  // Reads already in the RAM pipeline hold a FIFO slot, so the FIFO cannot overflow
  assign w_credit  = (w_fifo_count + w_inflight) < CW'(FIFO_DEPTH);
  assign w_issue   = (r_state == RUN) && w_credit;
  assign w_valid   = !w_fifo_empty;
  assign w_pop     = w_valid && m_ready;
  assign w_last_hs = w_pop && w_head[DATA];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_remain   <= '0;
      r_tag_vld  <= '0;
      r_tag_last <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_tag_vld  <= {r_tag_vld[PIPE_LAT-2:0], 1'b0};
      r_tag_last <= {r_tag_last[PIPE_LAT-2:0], 1'b0};
      case (r_state)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              r_done <= 1'b1;
            end else begin
              // The first read launches together with the start accept
              r_mem_addr    <= base_addr;
              r_addr        <= base_addr + ADDR'(1);
              r_remain      <= length - (ADDR+1)'(1);
              r_tag_vld[0]  <= 1'b1;
              r_tag_last[0] <= (length == (ADDR+1)'(1));
              r_busy        <= 1'b1;
              r_state       <= (length == (ADDR+1)'(1)) ? DRAIN : RUN;
            end
          end
        end
        RUN: begin
          if (w_issue) begin
            r_mem_addr    <= r_addr;
            r_addr        <= r_addr + ADDR'(1);
            r_remain      <= r_remain - (ADDR+1)'(1);
            r_tag_vld[0]  <= 1'b1;
            r_tag_last[0] <= (r_remain == (ADDR+1)'(1));
            if (r_remain == (ADDR+1)'(1)) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_last_hs) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  stream_fifo #(
    .WIDTH (DATA+1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_tag_vld[PIPE_LAT-1]),
    .din   ({r_tag_last[PIPE_LAT-1], mem_dout}),
    .pop   (w_pop),
    .head  (w_head),
    .count (w_fifo_count),
    .empty (w_fifo_empty)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_addr = r_mem_addr;
  assign mem_wr   = 1'b0;
  assign mem_din  = '0;
  assign m_data   = w_head[DATA-1:0];
  assign m_valid  = w_valid;
  assign m_last   = w_valid && w_head[DATA];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a one-register BRAM read model.
module tb_bram_stream_reader;

  localparam int DATA = 72;
  localparam int ADDR = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR-1:0]   base_addr;
  logic [ADDR:0]     length;
  logic              busy;
  logic              done;
  logic [ADDR-1:0]   mem_addr;
  logic              mem_wr;
  logic [DATA-1:0]   mem_din;
  logic [DATA-1:0]   mem_dout;
  logic [DATA-1:0]   m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;

  logic [DATA-1:0]   mem [1024];
  logic [DATA:0]     q[$];
  int                n_chk = 0;
  int                n_err = 0;
  int                rdy_mode = 0;
  int                max_occ = 0;
  logic              prev_stall = 1'b0;
  logic [DATA:0]     prev_word = '0;

  bram_stream_reader #(.DATA(DATA), .ADDR(ADDR)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= mem[mem_addr];

  function automatic logic [DATA-1:0] exp_word(input int k);
    logic [9:0] a;
    a = 10'(k);
    return {a ^ 10'h155, 52'h0, a};
  endfunction

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Beat capture, stall stability and FIFO occupancy tracking
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 80'(m_valid), 80'(1));
        chk("stall_word", 80'({m_last, m_data}), 80'(prev_word));
      end
      if (m_valid && m_ready) q.push_back({m_last, m_data});
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
      if (int'(u_dut.u_fifo.count) > max_occ) max_occ = int'(u_dut.u_fifo.count);
    end
  end

  // Ready driver: mode 1 opens every 24 cycles with a 10-cycle stall, then random
  initial begin
    int ph;
    ph = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) begin
        ph = 0;
        m_ready = 1'b1;
      end else begin
        m_ready = (ph % 24 < 10) ? 1'b0 : 1'($urandom_range(0, 1));
        ph++;
      end
    end
  end

  task automatic do_start(input int b, input int l);
    @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 10'(b);
    length = 11'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) chk("done_timeout", 80'(done), 80'(1));
  endtask

  task automatic verify_queue(input string tag, input int b, input int n);
    chk({tag, "_n"}, 80'(q.size()), 80'(n));
    for (int i = 0; i < n && i < q.size(); i++)
      chk(tag, 80'(q[i]), 80'({(i == n - 1), exp_word((b + i) % 1024)}));
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = exp_word(k);
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_done", 80'(done), 80'(0));
    chk("rst_valid", 80'(m_valid), 80'(0));
    chk("rst_last", 80'(m_last), 80'(0));
    chk("rst_wr", 80'(mem_wr), 80'(0));
    chk("rst_addr", 80'(mem_addr), 80'(0));
    chk("rst_din", 80'(mem_din), 80'(0));
    chk("rst_data", 80'(m_data), 80'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Cycle-exact run: base 5, length 8, ready high
    q.delete();
    do_start(5, 8);
    @(negedge clk);
    chk("c1_busy", 80'(busy), 80'(1));
    chk("c1_addr", 80'(mem_addr), 80'(5));
    chk("c1_valid", 80'(m_valid), 80'(0));
    @(negedge clk);
    chk("c2_valid", 80'(m_valid), 80'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_valid", 80'(m_valid), 80'(1));
      chk("t1_data", 80'(m_data), 80'(exp_word(5 + i)));
      chk("t1_last", 80'(m_last), 80'(i == 7));
      chk("t1_done", 80'(done), 80'(0));
    end
    @(negedge clk);
    chk("t1_done_pulse", 80'(done), 80'(1));
    chk("t1_busy_low", 80'(busy), 80'(0));
    @(negedge clk);
    chk("t1_done_end", 80'(done), 80'(0));
    verify_queue("t1", 5, 8);

    // Address wrap
    q.delete();
    do_start(10'h3FE, 4);
    wait_done(100);
    verify_queue("wrap", 10'h3FE, 4);

    // Backpressure with long stalls
    q.delete();
    max_occ = 0;
    rdy_mode = 1;
    do_start(100, 16);
    wait_done(2000);
    rdy_mode = 0;
    verify_queue("bp", 100, 16);
    chk("bp_max_occ", 80'(max_occ), 80'(4));

    // Zero length
    q.delete();
    do_start(33, 0);
    @(negedge clk);
    chk("z_done", 80'(done), 80'(1));
    chk("z_busy", 80'(busy), 80'(0));
    @(negedge clk);
    chk("z_done_end", 80'(done), 80'(0));
    repeat (5) @(negedge clk);
    chk("z_beats", 80'(q.size()), 80'(0));

    // Full 1024-word range, last word at base-1
    q.delete();
    do_start(7, 1024);
    wait_done(3000);
    verify_queue("full", 7, 1024);

    // Start while busy is ignored; restart in the done cycle is accepted
    q.delete();
    do_start(200, 12);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    base_addr = 10'd500;
    length = 11'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(200);
    verify_queue("ign", 200, 12);
    q.delete();
    start = 1'b1;
    base_addr = 10'd300;
    length = 11'd5;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("re_busy", 80'(busy), 80'(1));
    chk("re_addr", 80'(mem_addr), 80'(300));
    wait_done(200);
    verify_queue("re", 300, 5);

    // Reset mid-run after three beats
    q.delete();
    do_start(50, 10);
    for (int i = 0; i < 50 && q.size() < 3; i++) @(negedge clk);
    chk("mr_beats", 80'(q.size()), 80'(3));
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_busy", 80'(busy), 80'(0));
    chk("mr_valid", 80'(m_valid), 80'(0));
    chk("mr_last", 80'(m_last), 80'(0));
    chk("mr_data", 80'(m_data), 80'(0));
    chk("mr_addr", 80'(mem_addr), 80'(0));
    chk("mr_done", 80'(done), 80'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete();
    do_start(60, 2);
    wait_done(100);
    verify_queue("post", 60, 2);
    repeat (10) @(negedge clk);
    chk("post_extra", 80'(q.size()), 80'(2));
    chk("post_done", 80'(done), 80'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
